mem_access: RTL

//  MEM stage of the 5-stage pipeline. Sits between ex_mem and mem_wb.
//  Non-memory instructions pass through combinationally. Loads and stores run

---
 rtl/mem_access.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: ALU results pass straight through, loads and stores are
// serialised over an 8-bit RAM port while the rest of the pipeline is stalled.
module mem_access #(
   parameter int MEM_ADDR_W = 32,
   parameter int REG_W      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_W-1:0]      ex_rd_data,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_rd_enable,
   input  logic                  ex_mem_load,
   input  logic                  ex_mem_store,
   input  logic [2:0]            ex_mem_funct3,
   input  logic [MEM_ADDR_W-1:0] ex_mem_addr,
   input  logic [REG_W-1:0]      ex_store_data,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [MEM_ADDR_W-1:0] mem_a,
   output logic                  mem_wr,
   output logic [REG_W-1:0]      mem_rd_data,
   output logic [REG_ADDR_W-1:0] mem_rd_addr,
   output logic                  mem_rd_enable,
   output logic                  stall_req
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [1:0]            r_cnt;
   logic [23:0]           r_buf;

   logic                  w_access;
   logic [1:0]            w_last_idx;
   logic [1:0]            w_idx;
   logic [MEM_ADDR_W-1:0] w_byte_addr;
   logic [7:0]            w_store_byte;
   logic [REG_W-1:0]      w_load_result;

   assign w_access    = ex_mem_load | ex_mem_store;
   assign w_last_idx  = ex_mem_funct3[1] ? 2'd3 : (ex_mem_funct3[0] ? 2'd1 : 2'd0);
   // The first byte is addressed from IDLE, so r_cnt only matters once the FSM has left it.
   assign w_idx       = (r_state == S_IDLE) ? 2'd0 : r_cnt;
   assign w_byte_addr = ex_mem_addr + {{(MEM_ADDR_W-2){1'b0}}, w_idx};

   always_comb begin
      w_store_byte = 8'h00;
      case (w_idx)
         2'd0:    w_store_byte = ex_store_data[7:0];
         2'd1:    w_store_byte = ex_store_data[15:8];
         2'd2:    w_store_byte = ex_store_data[23:16];
         2'd3:    w_store_byte = ex_store_data[31:24];
         default: w_store_byte = 8'h00;
      endcase
   end

   // The last byte is still on mem_din in DONE; earlier ones sit in r_buf.
   always_comb begin
      w_load_result = 32'h0000_0000;
      case (ex_mem_funct3[1:0])
         2'b00:   w_load_result = {{24{mem_din[7] & ~ex_mem_funct3[2]}}, mem_din};
         2'b01:   w_load_result = {{16{mem_din[7] & ~ex_mem_funct3[2]}}, mem_din, r_buf[7:0]};
         default: w_load_result = {mem_din, r_buf};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_buf   <= 24'h00_0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  r_cnt <= 2'd1;
                  if (w_last_idx == 2'd0) begin
                     r_state <= S_DONE;
                  end else if (ex_mem_load) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_state <= S_STORE;
                  end
               end else begin
                  r_cnt <= 2'd0;
               end
            end
            S_LOAD: begin
               case (r_cnt)
                  2'd1:    r_buf[7:0]   <= mem_din;
                  2'd2:    r_buf[15:8]  <= mem_din;
                  2'd3:    r_buf[23:16] <= mem_din;
                  default: r_buf        <= r_buf;
               endcase
               if (r_cnt == w_last_idx) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_STORE: begin
               if (r_cnt == w_last_idx) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_cnt   <= 2'd0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   // Outputs are forced low while reset is held, whatever state was active.
   always_comb begin
      mem_dout      = 8'h00;
      mem_a         = {MEM_ADDR_W{1'b0}};
      mem_wr        = 1'b0;
      mem_rd_data   = {REG_W{1'b0}};
      mem_rd_addr   = {REG_ADDR_W{1'b0}};
      mem_rd_enable = 1'b0;
      stall_req     = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  mem_a     = w_byte_addr;
                  stall_req = 1'b1;
                  if (!ex_mem_load) begin
                     mem_wr   = 1'b1;
                     mem_dout = w_store_byte;
                  end else begin
                     mem_wr   = 1'b0;
                  end
               end else begin
                  mem_rd_data   = ex_rd_data;
                  mem_rd_addr   = ex_rd_addr;
                  mem_rd_enable = ex_rd_enable;
               end
            end
            S_LOAD: begin
               mem_a     = w_byte_addr;
               stall_req = 1'b1;
            end
            S_STORE: begin
               mem_a     = w_byte_addr;
               mem_wr    = 1'b1;
               mem_dout  = w_store_byte;
               stall_req = 1'b1;
            end
            S_DONE: begin
               if (ex_mem_load) begin
                  mem_rd_data   = w_load_result;
                  mem_rd_addr   = ex_rd_addr;
                  mem_rd_enable = ex_rd_enable;
               end else begin
                  mem_rd_enable = 1'b0;
               end
            end
            default: begin
               stall_req = 1'b0;
            end
         endcase
      end else begin
         stall_req = 1'b0;
      end
   end

endmodule
